keypad_multitap: RTL

Scans the 4x4 player/host keypad, debounces it, and turns phone-style multi-tap presses into one ASCII letter per submit. It sits directly upstream of the game controller in `main`, with one instance per side. It drives the keypad columns, reads the `input_row_*` lines, and hands the controller a committed letter plus a live preview letter for the LCD row.

---
 rtl/keypad_pkg.sv | 82 ++++++++
 rtl/keypad_scan_debounce.sv | 97 +++++++++
 rtl/keypad_multitap.sv | 125 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key tables for the multi-tap keypad.
// KEYPAD_CLEAR_KEY_EN makes R3C3 decode as CLEAR; otherwise it is an ignored key.
package keypad_pkg;

  typedef enum logic [3:0] {
    NONE   = 4'd0,
    K_ABC  = 4'd1,
    K_DEF  = 4'd2,
    K_GHI  = 4'd3,
    K_JKL  = 4'd4,
    K_MNO  = 4'd5,
    K_PQRS = 4'd6,
    K_TUV  = 4'd7,
    K_WXYZ = 4'd8,
    SUBMIT = 4'd9,
    CLEAR  = 4'd10
  } key_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  function automatic logic is_letter_key(input key_t k);
    return (k >= K_ABC) && (k <= K_WXYZ);
  endfunction

  function automatic logic [2:0] key_letter_count(input key_t k);
    case (k)
      K_PQRS, K_WXYZ:                               return 3'd4;
      K_ABC, K_DEF, K_GHI, K_JKL, K_MNO, K_TUV:     return 3'd3;
      default:                                      return 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] key_base_ascii(input key_t k);
    case (k)
      K_ABC:   return 8'h41;
      K_DEF:   return 8'h44;
      K_GHI:   return 8'h47;
      K_JKL:   return 8'h4A;
      K_MNO:   return 8'h4D;
      K_PQRS:  return 8'h50;
      K_TUV:   return 8'h54;
      K_WXYZ:  return 8'h57;
      default: return 8'h00;
    endcase
  endfunction

  // row[3] is R0, so it is tested first to give R0 priority within a column.
  function automatic key_t decode_column(input logic [1:0] col, input logic [3:0] row);
    case (col)
      2'd0: begin
        if (row[3])      return K_ABC;
        else if (row[2]) return K_JKL;
        else if (row[1]) return K_TUV;
        else if (row[0]) return SUBMIT;
        else             return NONE;
      end
      2'd1: begin
        if (row[3])      return K_DEF;
        else if (row[2]) return K_MNO;
        else if (row[1]) return K_WXYZ;
        else             return NONE;
      end
      2'd2: begin
        if (row[3])      return K_GHI;
        else if (row[2]) return K_PQRS;
        else             return NONE;
      end
      default: begin
`ifdef KEYPAD_CLEAR_KEY_EN
        if (row[0])      return CLEAR;
        else             return NONE;
`else
        return NONE;
`endif
      end
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Column scanner and frame debouncer: produces the debounced key and a
// one-cycle press event on each NONE -> key transition.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output key_t       key_o,
  output logic       press_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       col_idx_q, col_idx_d;
  key_t             frame_q, frame_d, cand_q, cand_d, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  key_t             col_key_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      col_q     <= 4'b0001;
      col_idx_q <= 2'd0;
      frame_q   <= NONE;
      cand_q    <= NONE;
      cnt_q     <= '0;
      deb_q     <= NONE;
      press_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      frame_q   <= frame_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      press_q   <= press_d;
    end
  end

  always_comb begin
    div_d     = div_q;
    col_d     = col_q;
    col_idx_d = col_idx_q;
    frame_d   = frame_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    press_d   = 1'b0;
    col_key_s = decode_column(col_idx_q, row_in);
    if (div_q == DIV_LAST) begin
      div_d     = '0;
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
      // C0 starts a new frame; later columns only fill in if nothing was seen yet.
      if ((col_idx_q == 2'd0) || (frame_q == NONE)) begin
        frame_d = col_key_s;
      end else begin
        frame_d = frame_q;
      end
      if (col_idx_q == 2'd3) begin
        if (frame_d == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cand_d = frame_d;
          cnt_d  = CNT_W'(1);
        end
        if ((cnt_d >= CNT_MAX) && (deb_q != cand_d)) begin
          deb_d   = cand_d;
          press_d = (deb_q == NONE);
        end else begin
          deb_d   = deb_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign col_out = col_q;
  assign key_o   = deb_q;
  assign press_o = press_q;

endmodule

// File: rtl/keypad_multitap.sv
// Multi-tap letter entry on top of the scanned keypad.
// KEYPAD_CLEAR_KEY_EN enables the R3C3 clear key.
module keypad_multitap
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int TAP_TIMEOUT     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] cur_letter,
  output logic       letter_valid,
  output logic [7:0] letter,
  output logic       error
);

  localparam int TMR_W = $clog2(TAP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TAP_TIMEOUT);

  key_t             deb_key_s;
  logic             press_s;
  state_t           state_q, state_d;
  key_t             key_q, key_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       next_idx_s;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       cur_q, cur_d, letter_q, letter_d;
  logic             valid_q, valid_d, err_q, err_d;

  keypad_scan_debounce #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .key_o   (deb_key_s),
    .press_o (press_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      key_q    <= NONE;
      idx_q    <= 2'd0;
      tmr_q    <= '0;
      cur_q    <= 8'd0;
      letter_q <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      cur_q    <= cur_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    idx_d      = idx_q;
    letter_d   = letter_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    next_idx_s = {1'b0, idx_q} + 3'd1;
    if ((state_q == ST_PENDING) && (tmr_q != TMR_MAX)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = tmr_q;
    end
    if (press_s) begin
      if (is_letter_key(deb_key_s)) begin
        // Same key inside the tap window advances; anything else restarts on the new key.
        if ((state_q == ST_PENDING) && (deb_key_s == key_q) && (tmr_q != TMR_MAX)) begin
          idx_d = (next_idx_s == key_letter_count(key_q)) ? 2'd0 : next_idx_s[1:0];
        end else begin
          idx_d = 2'd0;
          key_d = deb_key_s;
        end
        state_d = ST_PENDING;
        tmr_d   = '0;
      end else if (deb_key_s == SUBMIT) begin
        if (state_q == ST_PENDING) begin
          letter_d = cur_q;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          err_d    = 1'b1;
        end
      end else begin
`ifdef KEYPAD_CLEAR_KEY_EN
        if ((deb_key_s == CLEAR) && (state_q == ST_PENDING)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
`else
        state_d = state_q;
`endif
      end
    end else begin
      state_d = state_q;
    end
    if (state_d == ST_PENDING) begin
      cur_d = key_base_ascii(key_d) + {6'd0, idx_d};
    end else begin
      cur_d = 8'd0;
    end
  end

  assign cur_letter   = cur_q;
  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign error        = err_q;

endmodule
